// File: rtl/neuron_pkg.sv
// Shared types and sizing helpers for the neuron datapath stages.
package neuron_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    ACT,
    OUT
  } state_e;

  localparam int unsigned SUM_WIDTH_DEF = 16;
  localparam int unsigned OUT_WIDTH_DEF = 8;

  // Smallest signed accumulator that holds a bias plus chunk_count full-scale sums.
  function automatic int unsigned min_acc_width(input int unsigned sum_w,
                                                input int unsigned chunk_count);
    return sum_w + $clog2(chunk_count) + 2;
  endfunction

endpackage

// File: rtl/relu_saturate.sv
// ReLU with unsigned saturation from a signed accumulator to OUT_WIDTH bits.
module relu_saturate #(
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [OUT_WIDTH-1:0] act,
  output logic                        sat
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_ACT =
    {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  if (ACC_WIDTH <= OUT_WIDTH) begin : g_width_chk
    $error("relu_saturate: ACC_WIDTH must exceed OUT_WIDTH");
  end

  always_comb begin
    act = acc[OUT_WIDTH-1:0];
    sat = 1'b0;
    if (acc < 0) begin
      act = '0;
    end else if (acc > MAX_ACT) begin
      act = '1;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_accumulate_activate.sv
// Accumulates partial weighted sums plus bias, then emits a ReLU/saturated activation.
module neuron_accumulate_activate
  import neuron_pkg::*;
#(
  parameter int unsigned SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int unsigned CHUNK_COUNT = 4,
  parameter int unsigned ACC_WIDTH   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_WIDTH-1:0] in_sum,
  input  logic                 in_last,
  input  logic [ACC_WIDTH-1:0] bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_act,
  output logic                 out_sat,
  output logic                 out_err
);

  localparam int unsigned CNT_W = $clog2(CHUNK_COUNT + 1);

  if (CHUNK_COUNT < 1) begin : g_chunk_chk
    $error("neuron_accumulate_activate: CHUNK_COUNT must be at least 1");
  end
  if (ACC_WIDTH < min_acc_width(SUM_WIDTH, CHUNK_COUNT)) begin : g_acc_width_chk
    $error("neuron_accumulate_activate: ACC_WIDTH too small for SUM_WIDTH/CHUNK_COUNT");
  end

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0]     cnt_q, cnt_d;
  logic                        pend_q, pend_d;
  logic                        valid_q, valid_d;
  logic        [OUT_WIDTH-1:0] act_q, act_d;
  logic                        sat_q, sat_d;
  logic                        err_q, err_d;

  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] sum_ext;
  logic                        last_chunk;
  logic        [OUT_WIDTH-1:0] relu_act;
  logic                        relu_sat;

  relu_saturate #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_relu (
    .acc(acc_q),
    .act(relu_act),
    .sat(relu_sat)
  );

  assign in_ready   = (state_q == ACCUM) && !rst;
  assign out_valid  = valid_q;
  assign out_act    = act_q;
  assign out_sat    = sat_q;
  assign out_err    = err_q;

  // The first beat of a neuron starts from the bias rather than the stale sum.
  assign acc_base   = (cnt_q == '0) ? $signed(bias) : acc_q;
  assign sum_ext    = {{(ACC_WIDTH-SUM_WIDTH){1'b0}}, in_sum};
  assign last_chunk = (cnt_q == CNT_W'(CHUNK_COUNT - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    act_d   = act_q;
    sat_d   = sat_q;
    err_d   = err_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid && in_ready) begin
          acc_d = acc_base + sum_ext;
          cnt_d = cnt_q + CNT_W'(1);
          if (in_last || last_chunk) begin
            pend_d  = !in_last;
            state_d = ACT;
          end
        end
      end
      ACT: begin
        act_d   = relu_act;
        sat_d   = relu_sat;
        err_d   = pend_q;
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      act_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      act_q   <= act_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_neuron_accumulate_activate.sv
// Directed scoreboard bench for neuron_accumulate_activate.
module tb_neuron_accumulate_activate;

  localparam int SUM_W = 16;
  localparam int OUT_W = 8;
  localparam int ACC_W = 24;

  typedef struct {
    logic [OUT_W-1:0] act;
    logic             sat;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             in_last;
  logic [ACC_W-1:0] bias;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_act;
  logic             out_sat;
  logic             out_err;

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];

  neuron_accumulate_activate #(
    .SUM_WIDTH(SUM_W),
    .OUT_WIDTH(OUT_W),
    .CHUNK_COUNT(4),
    .ACC_WIDTH(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_last(in_last),
    .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_act(out_act), .out_sat(out_sat), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference activation from a bias and the integer sum of the chunks.
  function automatic exp_t model(input longint b, input longint total, input logic err);
    exp_t e;
    longint a;
    a = b + total;
    e.err = err;
    if (a < 0) begin
      e.act = '0; e.sat = 1'b0;
    end else if (a > 255) begin
      e.act = '1; e.sat = 1'b1;
    end else begin
      e.act = a[OUT_W-1:0]; e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic send_beat(input string tag, input int sum, input logic last, input int b);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_sum   = SUM_W'(sum);
    in_last  = last;
    bias     = ACC_W'(b);
    for (int i = 0; i < 30 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_accepted"}, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  // Compare the presented activation against the scoreboard head, then handshake.
  task automatic take_output(input string tag);
    exp_t e;
    wait_valid(tag);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_act"}, 32'(out_act), 32'(e.act));
      check({tag, "_sat"}, 32'(out_sat), 32'(e.sat));
      check({tag, "_err"}, 32'(out_err), 32'(e.err));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_last = 1'b0; bias = '0; out_ready = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_act", 32'(out_act), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: single beat with negative bias, latency check
    exp_q.push_back(model(-20, 100, 1'b0));
    send_beat("t1", 100, 1'b1, -20);
    check("t1_act_cycle_valid", 32'(out_valid), 32'd0);
    check("t1_act_cycle_ready", 32'(in_ready), 32'd0);
    tick();
    check("t1_t2_valid", 32'(out_valid), 32'd1);
    take_output("t1");

    // 2: three chunks saturating
    exp_q.push_back(model(0, 350, 1'b0));
    send_beat("t2a", 100, 1'b0, 0);
    send_beat("t2b", 200, 1'b0, 999);
    send_beat("t2c", 50, 1'b1, 999);
    take_output("t2");

    // 3: negative result clips to zero, then bias is resampled
    exp_q.push_back(model(-50, 10, 1'b0));
    send_beat("t3a", 10, 1'b1, -50);
    take_output("t3a");
    exp_q.push_back(model(5, 3, 1'b0));
    send_beat("t3b", 3, 1'b1, 5);
    take_output("t3b");

    // 4: backpressure holds output stable and blocks input
    exp_q.push_back(model(-20, 100, 1'b0));
    send_beat("t4", 100, 1'b1, -20);
    wait_valid("t4");
    in_valid = 1'b1; in_sum = 16'd1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_act", 32'(out_act), 32'd80);
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    take_output("t4");

    // 5: chunk limit forces the end and flags the error
    exp_q.push_back(model(0, 40, 1'b1));
    for (int i = 0; i < 4; i++) send_beat("t5", 10, 1'b0, 0);
    in_valid = 1'b1; in_sum = 16'd10; in_last = 1'b1; bias = '0;
    check("t5_act_blocks", 32'(in_ready), 32'd0);
    tick();
    check("t5_out_blocks", 32'(in_ready), 32'd0);
    take_output("t5");
    exp_q.push_back(model(0, 10, 1'b0));
    send_beat("t5_fifth", 10, 1'b1, 0);
    take_output("t5_fifth");

    // 6: reset mid-accumulation discards the partial neuron
    send_beat("t6a", 100, 1'b0, 0);
    send_beat("t6b", 100, 1'b0, 0);
    rst = 1'b1;
    #1;
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_post_in_ready", 32'(in_ready), 32'd1);
    check("t6_post_out_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(model(0, 7, 1'b0));
    send_beat("t6c", 7, 1'b1, 0);
    take_output("t6");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
